// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_op_sequencer
//  Purpose  : Sequential front-end for a 4-bit combinational op unit. Accepts
//             one request at a time on a valid/ready interface, drives the
//             unit's operand/select from registers, waits SETTLE_CYC cycles,
//             captures the unit's result and returns it on a valid/ready
//             response interface. Sweep mode runs selects 0..3 on one operand
//             and returns four responses.
//  Ports    : clk, rst_n (sync, active-low)
//             req_valid/req_ready/req_a/req_sel/req_sweep  - request side
//             alu_a/alu_sel (out), alu_out (in)            - op unit side
//             rsp_valid/rsp_ready/rsp_data/rsp_sel/rsp_last - response side
//             op_count - completed response handshakes (wraps), busy
//  Revision : 1.0 - initial release
// ============================================================================
module alu_op_sequencer #(
    parameter int SETTLE_CYC = 1,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_a,
    input  logic [1:0]       req_sel,
    input  logic             req_sweep,
    output logic [3:0]       alu_a,
    output logic [1:0]       alu_sel,
    input  logic [3:0]       alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [3:0]       rsp_data,
    output logic [1:0]       rsp_sel,
    output logic             rsp_last,
    output logic [CNT_W-1:0] op_count,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] c_settle_cyc = 4'(SETTLE_CYC);

    state_t             state_q,     state_d;
    logic [3:0]         cnt_q,       cnt_d;
    logic               sweep_q,     sweep_d;
    logic [3:0]         alu_a_q,     alu_a_d;
    logic [1:0]         alu_sel_q,   alu_sel_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [3:0]         rsp_data_q,  rsp_data_d;
    logic [1:0]         rsp_sel_q,   rsp_sel_d;
    logic               rsp_last_q,  rsp_last_d;
    logic [CNT_W-1:0]   op_count_q,  op_count_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            sweep_q     <= 1'b0;
            alu_a_q     <= 4'd0;
            alu_sel_q   <= 2'd0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 4'd0;
            rsp_sel_q   <= 2'd0;
            rsp_last_q  <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sweep_q     <= sweep_d;
            alu_a_q     <= alu_a_d;
            alu_sel_q   <= alu_sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_sel_q   <= rsp_sel_d;
            rsp_last_q  <= rsp_last_d;
            op_count_q  <= op_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sweep_d     = sweep_q;
        alu_a_d     = alu_a_q;
        alu_sel_d   = alu_sel_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_sel_d   = rsp_sel_q;
        rsp_last_d  = rsp_last_q;
        op_count_d  = op_count_q;

        case (state_q)
            IDLE: begin
                // req_ready is implied by being in IDLE
                if (req_valid) begin
                    alu_a_d   = req_a;
                    alu_sel_d = req_sweep ? 2'd0 : req_sel;
                    sweep_d   = req_sweep;
                    cnt_d     = c_settle_cyc;
                    state_d   = SETTLE;
                end
            end
            SETTLE: begin
                cnt_d = cnt_q - 4'd1;
                // "<= 1" rather than "== 1" so an out-of-range zero setting
                // still terminates instead of wrapping through 15 cycles.
                if (cnt_q <= 4'd1) begin
                    rsp_data_d  = alu_out;
                    rsp_sel_d   = alu_sel_q;
                    rsp_last_d  = !sweep_q || (alu_sel_q == 2'd3);
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    op_count_d  = op_count_q + CNT_W'(1);
                    if (sweep_q && (alu_sel_q != 2'd3)) begin
                        alu_sel_d = alu_sel_q + 2'd1;
                        cnt_d     = c_settle_cyc;
                        state_d   = SETTLE;
                    end else begin
                        state_d   = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign alu_a     = alu_a_q;
    assign alu_sel   = alu_sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_sel   = rsp_sel_q;
    assign rsp_last  = rsp_last_q;
    assign op_count  = op_count_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_op_sequencer
//  Purpose  : Self-checking bench for alu_op_sequencer. A default instance
//             (SETTLE_CYC=1, CNT_W=8) covers reset, single, sweep,
//             backpressure and mid-sweep reset; a second instance
//             (SETTLE_CYC=3, CNT_W=2) covers latency and counter wrap.
//             Expected responses are queued at request time and compared
//             when the response appears.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;

    typedef struct packed {
        logic [1:0] sel;
        logic [3:0] data;
        logic       last;
    } exp_t;

    logic       clk;
    logic       rst_n;

    // default instance
    logic       req_valid, req_ready, req_sweep;
    logic [3:0] req_a;
    logic [1:0] req_sel;
    logic [3:0] alu_a, alu_out, rsp_data;
    logic [1:0] alu_sel, rsp_sel;
    logic       rsp_valid, rsp_ready, rsp_last, busy;
    logic [7:0] op_count;

    // parameterised instance
    logic       b_req_valid, b_req_ready, b_req_sweep;
    logic [3:0] b_req_a;
    logic [1:0] b_req_sel;
    logic [3:0] b_alu_a, b_alu_out, b_rsp_data;
    logic [1:0] b_alu_sel, b_rsp_sel;
    logic       b_rsp_valid, b_rsp_ready, b_rsp_last, b_busy;
    logic [1:0] b_op_count;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];
    logic [7:0] exp_cnt = 8'd0;

    // op unit stubs
    assign alu_out   = alu_a ^ {2'b00, alu_sel};
    assign b_alu_out = b_alu_a ^ {2'b00, b_alu_sel};

    alu_op_sequencer #(.SETTLE_CYC(1), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a),
        .req_sel(req_sel), .req_sweep(req_sweep),
        .alu_a(alu_a), .alu_sel(alu_sel), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_sel(rsp_sel), .rsp_last(rsp_last),
        .op_count(op_count), .busy(busy)
    );

    alu_op_sequencer #(.SETTLE_CYC(3), .CNT_W(2)) u_dut_p (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_a(b_req_a),
        .req_sel(b_req_sel), .req_sweep(b_req_sweep),
        .alu_a(b_alu_a), .alu_sel(b_alu_sel), .alu_out(b_alu_out),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data),
        .rsp_sel(b_rsp_sel), .rsp_last(b_rsp_last),
        .op_count(b_op_count), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b1; req_a = 4'hF; req_sel = 2'd0;
        req_sweep = 1'b0; rsp_ready = 1'b1;
        b_req_valid = 1'b0; b_req_a = 4'h0; b_req_sel = 2'd0;
        b_req_sweep = 1'b0; b_rsp_ready = 1'b0;
        repeat (3) step();
        checks++;
        if (alu_a !== 4'h0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_accept: alu_a=%h busy=%b required alu_a=0 busy=0", alu_a, busy);
        end
        req_valid = 1'b0;
        rst_n = 1'b1;
        step();
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: req_ready=%b rsp_valid=%b busy=%b required 1 0 0",
                     req_ready, rsp_valid, busy);
        end
        checks++;
        if (alu_a !== 4'h0 || rsp_data !== 4'h0 || op_count !== 8'h00) begin
            failures++;
            $display("FAIL reset_data: alu_a=%h rsp_data=%h op_count=%h required 0 0 0",
                     alu_a, rsp_data, op_count);
        end
    endtask

    task automatic test_single();
        int   lat;
        exp_t e;
        req_a = 4'hB; req_sel = 2'd2; req_sweep = 1'b0; rsp_ready = 1'b1;
        req_valid = 1'b1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_ready: got %b required 1", req_ready);
        end
        sb_q.push_back('{sel: 2'd2, data: 4'h9, last: 1'b1});
        step();
        req_valid = 1'b0;
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        checks++;
        if (lat !== 1) begin
            failures++;
            $display("FAIL single_latency: got %0d edges after accept required 1", lat);
        end
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL single_sb: scoreboard empty");
        end else begin
            e = sb_q.pop_front();
            if (rsp_sel !== e.sel || rsp_data !== e.data || rsp_last !== e.last) begin
                failures++;
                $display("FAIL single_rsp: sel=%0d data=%h last=%b required %0d %h %b",
                         rsp_sel, rsp_data, rsp_last, e.sel, e.data, e.last);
            end
        end
        step();
        exp_cnt = exp_cnt + 8'd1;
        checks++;
        if (op_count !== exp_cnt || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL single_done: op_count=%0d rsp_valid=%b req_ready=%b required %0d 0 1",
                     op_count, rsp_valid, req_ready, exp_cnt);
        end
    endtask

    task automatic test_sweep();
        int   n;
        int   cyc;
        exp_t e;
        req_a = 4'h5; req_sweep = 1'b1; req_sel = 2'd2; req_valid = 1'b1;
        rsp_ready = 1'b1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL sweep_ready: got %b required 1", req_ready);
        end
        for (int s = 0; s < 4; s++)
            sb_q.push_back('{sel: 2'(s), data: 4'h5 ^ 4'(s), last: (s == 3)});
        step();
        // keep a competing request asserted; it must not be taken mid-sweep
        req_a = 4'h3; req_sel = 2'd1; req_sweep = 1'b0;
        n = 0; cyc = 0;
        while (n < 4 && cyc < 100) begin
            checks++;
            if (req_ready !== 1'b0 || alu_a !== 4'h5) begin
                failures++;
                $display("FAIL sweep_hold: req_ready=%b alu_a=%h required 0 5", req_ready, alu_a);
            end
            if (rsp_valid === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL sweep_sb: scoreboard empty");
                end else begin
                    e = sb_q.pop_front();
                    if (rsp_sel !== e.sel || rsp_data !== e.data || rsp_last !== e.last) begin
                        failures++;
                        $display("FAIL sweep_rsp%0d: sel=%0d data=%h last=%b required %0d %h %b",
                                 n, rsp_sel, rsp_data, rsp_last, e.sel, e.data, e.last);
                    end
                end
                n++;
            end
            step();
            cyc++;
        end
        req_valid = 1'b0;
        exp_cnt = exp_cnt + 8'd4;
        checks++;
        if (n !== 4 || op_count !== exp_cnt || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL sweep_done: responses=%0d op_count=%0d req_ready=%b required 4 %0d 1",
                     n, op_count, req_ready, exp_cnt);
        end
    endtask

    task automatic test_backpressure();
        int   lat;
        exp_t e;
        req_a = 4'h6; req_sel = 2'd1; req_sweep = 1'b0; req_valid = 1'b1;
        rsp_ready = 1'b0;
        sb_q.push_back('{sel: 2'd1, data: 4'h7, last: 1'b1});
        step();
        // new request held pending while the response is stalled
        req_a = 4'hC; req_sel = 2'd3;
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 4'h7 || rsp_sel !== 2'd1 || req_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_stable%0d: valid=%b data=%h sel=%0d req_ready=%b required 1 7 1 0",
                         i, rsp_valid, rsp_data, rsp_sel, req_ready);
            end
            step();
        end
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL bp_sb: scoreboard empty");
        end else begin
            e = sb_q.pop_front();
            if (rsp_data !== e.data || rsp_last !== e.last) begin
                failures++;
                $display("FAIL bp_rsp: data=%h last=%b required %h %b", rsp_data, rsp_last, e.data, e.last);
            end
        end
        rsp_ready = 1'b1;
        step();
        exp_cnt = exp_cnt + 8'd1;
        checks++;
        if (op_count !== exp_cnt || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_handshake: op_count=%0d rsp_valid=%b req_ready=%b required %0d 0 1",
                     op_count, rsp_valid, req_ready, exp_cnt);
        end
        sb_q.push_back('{sel: 2'd3, data: 4'hF, last: 1'b1});
        step();
        req_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || alu_a !== 4'hC || alu_sel !== 2'd3) begin
            failures++;
            $display("FAIL bp_pending_accept: busy=%b alu_a=%h alu_sel=%0d required 1 C 3",
                     busy, alu_a, alu_sel);
        end
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL bp2_sb: scoreboard empty");
        end else begin
            e = sb_q.pop_front();
            if (rsp_valid !== 1'b1 || rsp_sel !== e.sel || rsp_data !== e.data || rsp_last !== e.last) begin
                failures++;
                $display("FAIL bp2_rsp: valid=%b sel=%0d data=%h last=%b required 1 %0d %h %b",
                         rsp_valid, rsp_sel, rsp_data, rsp_last, e.sel, e.data, e.last);
            end
        end
        step();
        exp_cnt = exp_cnt + 8'd1;
        checks++;
        if (op_count !== exp_cnt) begin
            failures++;
            $display("FAIL bp2_count: op_count=%0d required %0d", op_count, exp_cnt);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int   n;
        int   cyc;
        int   seen;
        exp_t e;
        req_a = 4'hA; req_sweep = 1'b1; req_sel = 2'd0; req_valid = 1'b1;
        rsp_ready = 1'b1;
        for (int s = 0; s < 4; s++)
            sb_q.push_back('{sel: 2'(s), data: 4'hA ^ 4'(s), last: (s == 3)});
        step();
        req_valid = 1'b0;
        n = 0; cyc = 0;
        while (n < 2 && cyc < 50) begin
            if (rsp_valid === 1'b1) begin
                checks++;
                e = sb_q.pop_front();
                if (rsp_sel !== e.sel || rsp_data !== e.data || rsp_last !== e.last) begin
                    failures++;
                    $display("FAIL midrst_rsp%0d: sel=%0d data=%h last=%b required %0d %h %b",
                             n, rsp_sel, rsp_data, rsp_last, e.sel, e.data, e.last);
                end
                n++;
            end
            step();
            cyc++;
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        sb_q.delete();
        exp_cnt = 8'd0;
        checks++;
        if (n !== 2 || busy !== 1'b0 || rsp_valid !== 1'b0 || op_count !== 8'd0 || alu_sel !== 2'd0) begin
            failures++;
            $display("FAIL midrst_state: rsps=%0d busy=%b rsp_valid=%b op_count=%0d alu_sel=%0d required 2 0 0 0 0",
                     n, busy, rsp_valid, op_count, alu_sel);
        end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_valid === 1'b1) seen++;
            step();
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL midrst_no_rsp: stray response cycles=%0d required 0", seen);
        end
    endtask

    task automatic test_params();
        int         lat;
        exp_t       e;
        logic [1:0] b_exp_cnt;
        b_exp_cnt = 2'd0;
        b_rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            b_req_a = 4'(i * 3 + 1); b_req_sel = 2'(i); b_req_sweep = 1'b0;
            b_req_valid = 1'b1;
            checks++;
            if (b_req_ready !== 1'b1) begin
                failures++;
                $display("FAIL param_ready%0d: got %b required 1", i, b_req_ready);
            end
            sb_q.push_back('{sel: 2'(i), data: 4'(i * 3 + 1) ^ {2'b00, 2'(i)}, last: 1'b1});
            step();
            b_req_valid = 1'b0;
            lat = 0;
            while (b_rsp_valid !== 1'b1 && lat < 30) begin
                step();
                lat++;
            end
            checks++;
            if (lat !== 3) begin
                failures++;
                $display("FAIL param_latency%0d: got %0d edges after accept required 3", i, lat);
            end
            checks++;
            e = sb_q.pop_front();
            if (b_rsp_sel !== e.sel || b_rsp_data !== e.data || b_rsp_last !== e.last) begin
                failures++;
                $display("FAIL param_rsp%0d: sel=%0d data=%h last=%b required %0d %h %b",
                         i, b_rsp_sel, b_rsp_data, b_rsp_last, e.sel, e.data, e.last);
            end
            step();
            b_exp_cnt = b_exp_cnt + 2'd1;
            checks++;
            if (b_op_count !== b_exp_cnt) begin
                failures++;
                $display("FAIL param_count%0d: op_count=%0d required %0d", i, b_op_count, b_exp_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_sweep();
        test_backpressure();
        test_reset_mid_sweep();
        test_params();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
